// File: rtl/prv_clint_pkg.sv
// prv_clint shared types and address map.
// Optional prescaler build: CLINT_PRESCALER_EN.
package prv_clint_pkg;

  localparam int unsigned MAX_HARTS = 8;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

  typedef logic [31:0] clint_word_t;
  typedef logic [63:0] clint_time_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP,
    SEL_MTIME
  } clint_sel_e;

endpackage

// File: rtl/prv_clint_tick.sv
// mtime tick generator: halt gating plus optional
// prescaler (CLINT_PRESCALER_EN).
module prv_clint_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic time_halt,
  input  logic mtime_wr,
  output logic tick
);

`ifdef CLINT_PRESCALER_EN
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = ~time_halt & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (mtime_wr) begin
      cnt <= '0;
    end else if (!time_halt) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, mtime_wr, 16'(PRESCALE)};
  assign tick = ~time_halt;
`endif

endmodule

// File: rtl/prv_clint.sv
// Machine timer / software interrupt unit.
// Optional prescaler build: CLINT_PRESCALER_EN.
module prv_clint
  import prv_clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ren,
  input  logic                 wen,
  input  logic [15:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  output logic                 err,
  input  logic                 time_halt,
  output logic [63:0]          mtime,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);

  clint_sel_e  sel;
  logic [2:0]  hidx;
  logic        hi;
  logic        aligned;
  logic        ok;
  logic        wr;
  logic        rd;
  logic        mt_wr_lo;
  logic        mt_wr_hi;
  logic        tick;
  clint_time_t cmp [NUM_HARTS];
  clint_time_t cmp_sel;
  logic        sip_sel;
  clint_word_t rword;

  assign aligned = (addr[1:0] == 2'b00);
  assign hi      = addr[2];

  always_comb begin
    sel  = SEL_NONE;
    hidx = '0;
    unique case (1'b1)
      aligned && (addr[15:5] == CLINT_MSIP_BASE[15:5]): begin
        hidx = addr[4:2];
        sel  = SEL_MSIP;
      end
      aligned && (addr[15:6] == CLINT_MTIMECMP_BASE[15:6]): begin
        hidx = addr[5:3];
        sel  = SEL_CMP;
      end
      (addr == CLINT_MTIME_LO), (addr == CLINT_MTIME_HI): begin
        sel = SEL_MTIME;
      end
      default: sel = SEL_NONE;
    endcase
    if (32'(hidx) >= NUM_HARTS) sel = SEL_NONE;
  end

  assign ok       = (sel != SEL_NONE);
  assign wr       = wen & ok;
  assign rd       = ren & ~wen;
  assign mt_wr_lo = wr && (sel == SEL_MTIME) && !hi;
  assign mt_wr_hi = wr && (sel == SEL_MTIME) && hi;

  prv_clint_tick #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk       (CLK),
    .rst       (RST),
    .time_halt (time_halt),
    .mtime_wr  (mt_wr_lo | mt_wr_hi),
    .tick      (tick)
  );

  // a half write wins over the tick; the other half is left alone
  always_ff @(posedge CLK) begin
    if (RST) begin
      mtime <= '0;
    end else if (mt_wr_lo) begin
      mtime[31:0] <= wdata;
    end else if (mt_wr_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic        hsel;
    clint_time_t cmp_q;
    logic        sip_q;
    logic        tip_q;

    assign hsel = wr && (hidx == 3'(h));

    always_ff @(posedge CLK) begin
      if (RST) begin
        cmp_q <= '1;
        sip_q <= 1'b0;
        tip_q <= 1'b0;
      end else begin
        if (hsel && (sel == SEL_CMP) && !hi)
          cmp_q[31:0] <= wdata;
        if (hsel && (sel == SEL_CMP) && hi)
          cmp_q[63:32] <= wdata;
        if (hsel && (sel == SEL_MSIP))
          sip_q <= wdata[0];
        tip_q <= (mtime >= cmp_q);
      end
    end

    assign cmp[h]  = cmp_q;
    assign msip[h] = sip_q;
    assign mtip[h] = tip_q;
  end

  always_comb begin
    cmp_sel = '0;
    sip_sel = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hidx == 3'(h)) begin
        cmp_sel = cmp[h];
        sip_sel = msip[h];
      end
    end
  end

  always_comb begin
    rword = '0;
    unique case (sel)
      SEL_MSIP:  rword = {31'b0, sip_sel};
      SEL_CMP:   rword = hi ? cmp_sel[63:32] : cmp_sel[31:0];
      SEL_MTIME: rword = hi ? mtime[63:32] : mtime[31:0];
      default:   rword = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd;
      err    <= (ren | wen) & ~ok;
      if (rd) rdata <= rword;
    end
  end

endmodule

// File: tb/tb_prv_clint.sv
// Directed self-checking bench for prv_clint.
// Works with or without CLINT_PRESCALER_EN.
module tb_prv_clint;

  localparam int unsigned NH = 2;
  localparam int unsigned PS = 4;
`ifdef CLINT_PRESCALER_EN
  localparam int TP = PS;
`else
  localparam int TP = 1;
`endif

  logic          CLK;
  logic          RST;
  logic          ren;
  logic          wen;
  logic [15:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          err;
  logic          time_halt;
  logic [63:0]   mtime;
  logic [NH-1:0] mtip;
  logic [NH-1:0] msip;

  int npass;
  int ntotal;

  prv_clint #(
    .NUM_HARTS (NH),
    .PRESCALE  (PS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ren       (ren),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .time_halt (time_halt),
    .mtime     (mtime),
    .mtip      (mtip),
    .msip      (msip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge CLK);
    wen = 1'b1;
    addr = a;
    wdata = d;
    @(negedge CLK);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a,
                    output logic [31:0] d,
                    output logic v,
                    output logic e);
    @(negedge CLK);
    ren = 1'b1;
    addr = a;
    @(negedge CLK);
    ren = 1'b0;
    d = rdata;
    v = rvalid;
    e = err;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [15:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic v;
    logic e;
    rd(a, d, v, e);
    check({tag, "_rvalid"}, 64'(v), 64'(1));
    check({tag, "_err"}, 64'(e), 64'(0));
    check(tag, 64'(d), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        v;
    logic        e;
    logic [31:0] lo_before;
    int          mt;
    int          prev;

    npass = 0;
    ntotal = 0;
    ren = 1'b0;
    wen = 1'b0;
    addr = '0;
    wdata = '0;
    time_halt = 1'b1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_mtime", mtime, 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_mtip", 64'(mtip), 64'(0));
    check("rst_msip", 64'(msip), 64'(0));
    RST = 1'b0;

    rd_chk("rd_mtime_lo", 16'hBFF8, 32'h0);
    rd_chk("rd_cmp0_lo", 16'h4000, 32'hFFFF_FFFF);
    rd_chk("rd_cmp0_hi", 16'h4004, 32'hFFFF_FFFF);
    rd_chk("rd_msip0", 16'h0000, 32'h0);
    check("rd_mtip", 64'(mtip), 64'(0));

    // mtimecmp[1] = 20, mtime from 0
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h0);
    wr(16'h400C, 32'h0);
    wr(16'h4008, 32'd20);
    time_halt = 1'b0;
    prev = 0;
    for (int n = 1; n <= 20 * TP + 2; n++) begin
      @(negedge CLK);
      mt = n / TP;
      check("mtime_cnt", mtime, 64'(mt));
      check("mtip1", 64'(mtip[1]), 64'(prev >= 20));
      check("mtip0", 64'(mtip[0]), 64'(0));
      prev = mt;
    end
    wr(16'h4008, 32'd100);
    check("mtip_hold", 64'(mtip[1]), 64'(1));
    @(negedge CLK);
    check("mtip_fall", 64'(mtip[1]), 64'(0));
    rd_chk("rd_cmp1_lo", 16'h4008, 32'd100);

    // wrap
    time_halt = 1'b1;
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    check("wrap_load", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    time_halt = 1'b0;
    repeat (TP) @(negedge CLK);
    check("wrap_m1", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (TP) @(negedge CLK);
    check("wrap_zero", mtime, 64'h0);

    // half writes while counting
    @(negedge CLK);
    lo_before = mtime[31:0];
    wen = 1'b1;
    addr = 16'hBFFC;
    wdata = 32'h5;
    @(negedge CLK);
    wen = 1'b0;
    check("hi_wr", mtime, {32'h5, lo_before});
    repeat (TP) @(negedge CLK);
    check("hi_wr_run", mtime, {32'h5, lo_before + 32'd1});
    wr(16'hBFF8, 32'h100);
    check("lo_wr", mtime, 64'h5_0000_0100);
    repeat (TP) @(negedge CLK);
    check("lo_wr_run", mtime, 64'h5_0000_0101);

    // software interrupt
    wr(16'h0004, 32'h1);
    check("msip_set", 64'(msip), 64'(2'b10));
    rd_chk("rd_msip1", 16'h0004, 32'h1);

    // error accesses
    rd(16'h0002, d, v, e);
    check("mis_rvalid", 64'(v), 64'(1));
    check("mis_err", 64'(e), 64'(1));
    check("mis_rdata", 64'(d), 64'(0));
    rd(16'h0010, d, v, e);
    check("hart_rvalid", 64'(v), 64'(1));
    check("hart_err", 64'(e), 64'(1));
    check("hart_rdata", 64'(d), 64'(0));
    wr(16'h8000, 32'h1);
    check("wr8000_err", 64'(err), 64'(1));
    wr(16'h4010, 32'h0);
    check("wr4010_err", 64'(err), 64'(1));
    check("err_msip", 64'(msip), 64'(2'b10));
    rd_chk("err_cmp1", 16'h4008, 32'd100);

    // read and write together
    @(negedge CLK);
    ren = 1'b1;
    wen = 1'b1;
    addr = 16'h0000;
    wdata = 32'h1;
    @(negedge CLK);
    ren = 1'b0;
    wen = 1'b0;
    check("rw_rvalid", 64'(rvalid), 64'(0));
    check("rw_msip", 64'(msip), 64'(2'b11));
    wr(16'h0004, 32'hFFFF_FFFE);
    check("msip_clr", 64'(msip), 64'(2'b01));

    // reset cancels a pending read
    @(negedge CLK);
    ren = 1'b1;
    addr = 16'hBFF8;
    RST = 1'b1;
    @(negedge CLK);
    ren = 1'b0;
    check("rst_cancel", 64'(rvalid), 64'(0));
    check("rst2_mtime", mtime, 64'(0));
    check("rst2_msip", 64'(msip), 64'(0));
    RST = 1'b0;

    // free run, then halt
    repeat (12) @(negedge CLK);
    check("run12", mtime, 64'(12 / TP));
    time_halt = 1'b1;
    repeat (5) @(negedge CLK);
    check("halt_hold", mtime, 64'(12 / TP));
    time_halt = 1'b0;
    repeat (TP - 1) @(negedge CLK);
    check("halt_cnt", mtime, 64'(12 / TP));
    @(negedge CLK);
    check("halt_resume", mtime, 64'(12 / TP + 1));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
